// File: rtl/raw_capture.sv
// raw_capture
// Turns raw sensor timing (frame valid, line valid, 12-bit Bayer pixel) into a
// coordinate-tagged pixel stream. Capture is gated by start/stop requests so
// that only whole frames are forwarded: a frame already in progress when
// capture is enabled is skipped, and a stop request never truncates a frame.
//
// State table
//   state      | meaning
//   -----------+------------------------------------------------------------
//   IDLE       | capture disabled, waiting for the run flag
//   WAIT_LOW   | run set; waiting for frame valid low so no partial frame is taken
//   WAIT_FRAME | waiting for a rising frame valid to start a new frame
//   ACTIVE     | inside a captured frame; pixels forwarded on line valid
module raw_capture #(
    parameter int COLUMN_WIDTH = 1280,
    parameter int ROW_HEIGHT   = 960
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iEND,
    input  logic        iFVAL,
    input  logic        iLVAL,
    input  logic [11:0] iDATA,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic        oBusy
);

    localparam logic [10:0] X_LAST = 11'(COLUMN_WIDTH - 1);
    localparam logic [10:0] Y_LAST = 11'(ROW_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_LOW   = 2'd1,
        WAIT_FRAME = 2'd2,
        ACTIVE     = 2'd3
    } state_t;

    state_t      state;
    logic        rF;
    logic        rL;
    logic        rF_d;
    logic        rL_d;
    logic [11:0] rD;
    logic        runFlag;
    logic [10:0] xCnt;
    logic [10:0] yCnt;

    logic        frameRise;
    logic        frameFall;
    logic        lineFall;
    logic        frameStart;
    logic        pixelFire;
    logic        shortLine;
    logic [10:0] yNext;

    // Edge detects and qualifiers, all taken from the registered sensor copies.
    assign frameRise  = rF & ~rF_d;
    assign frameFall  = ~rF & rF_d;
    assign lineFall   = ~rL & rL_d;
    assign frameStart = (state == WAIT_FRAME) & runFlag & frameRise;
    assign pixelFire  = (state == ACTIVE) & rF & rL;
    // A line that ended before the last column still owns a row; move to the next one.
    assign shortLine  = (state == ACTIVE) & lineFall & (xCnt != 11'd0);
    assign yNext      = (yCnt == Y_LAST) ? 11'd0 : yCnt + 11'd1;

    // Register the sensor pins once and keep the previous flags for edge detection.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rF   <= 1'b0;
            rL   <= 1'b0;
            rD   <= 12'd0;
            rF_d <= 1'b0;
            rL_d <= 1'b0;
        end else begin
            rF   <= iFVAL;
            rL   <= iLVAL;
            rD   <= iDATA;
            rF_d <= rF;
            rL_d <= rL;
        end
    end

    // Run flag: stop dominates start when both arrive in the same cycle.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            runFlag <= 1'b0;
        end else if (iEND) begin
            runFlag <= 1'b0;
        end else if (iSTART) begin
            runFlag <= 1'b1;
        end
    end

    // Capture sequencer with registered busy flag and completed-frame counter.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= IDLE;
            oBusy       <= 1'b0;
            oFrame_Cont <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (runFlag) begin
                        state <= WAIT_LOW;
                        oBusy <= 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (!runFlag) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end else if (!rF) begin
                        state <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (!runFlag) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end else if (frameRise) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // The run flag is only consulted at frame end, so a stop never cuts a frame short.
                    if (frameFall) begin
                        oFrame_Cont <= oFrame_Cont + 32'd1;
                        if (runFlag) begin
                            state <= WAIT_FRAME;
                        end else begin
                            state <= IDLE;
                            oBusy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

    // Column/row counters: cleared on frame entry, advanced per pixel and on short lines.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            xCnt <= 11'd0;
            yCnt <= 11'd0;
        end else if (frameStart) begin
            xCnt <= 11'd0;
            yCnt <= 11'd0;
        end else if (pixelFire) begin
            if (xCnt == X_LAST) begin
                xCnt <= 11'd0;
                yCnt <= yNext;
            end else begin
                xCnt <= xCnt + 11'd1;
            end
        end else if (shortLine) begin
            xCnt <= 11'd0;
            yCnt <= yNext;
        end
    end

    // Output stage: strobe valid per forwarded pixel, hold data and coordinates otherwise.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDATA   <= 12'd0;
            oDVAL   <= 1'b0;
            oX_Cont <= 11'd0;
            oY_Cont <= 11'd0;
        end else begin
            oDVAL <= pixelFire;
            if (pixelFire) begin
                oDATA   <= rD;
                oX_Cont <= xCnt;
                oY_Cont <= yCnt;
            end
        end
    end

endmodule

// File: tb/tb_raw_capture.sv
// Directed testbench for raw_capture with a 4x3 frame geometry.
module tb_raw_capture;

    localparam int CW = 4;
    localparam int RH = 3;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iSTART;
    logic        iEND;
    logic        iFVAL;
    logic        iLVAL;
    logic [11:0] iDATA;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [10:0] oX_Cont;
    logic [10:0] oY_Cont;
    logic [31:0] oFrame_Cont;
    logic        oBusy;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;

    typedef struct {
        int data;
        int x;
        int y;
        int cyc;
    } pix_t;

    pix_t logQ[$];
    int   drvQ[$];

    raw_capture #(
        .COLUMN_WIDTH(CW),
        .ROW_HEIGHT  (RH)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSTART     (iSTART),
        .iEND       (iEND),
        .iFVAL      (iFVAL),
        .iLVAL      (iLVAL),
        .iDATA      (iDATA),
        .oDATA      (oDATA),
        .oDVAL      (oDVAL),
        .oX_Cont    (oX_Cont),
        .oY_Cont    (oY_Cont),
        .oFrame_Cont(oFrame_Cont),
        .oBusy      (oBusy)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cycleCnt <= cycleCnt + 1;

    // Record every valid output beat together with the cycle it was seen in.
    always @(negedge iCLK) begin
        if (oDVAL === 1'b1)
            logQ.push_back('{data: int'(oDATA), x: int'(oX_Cont), y: int'(oY_Cont), cyc: cycleCnt});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic f, input logic l, input int d, input logic s, input logic e);
        @(negedge iCLK);
        iFVAL  = f;
        iLVAL  = l;
        iDATA  = 12'(d);
        iSTART = s;
        iEND   = e;
        if (f && l) drvQ.push_back(cycleCnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic frame_open;
        tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic send_line(input int n, input int base, input int endAt);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1, base + i, 1'b0, (i == endAt));
        tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic frame_close;
        idle(4);
    endtask

    task automatic send_frame(input int base);
        frame_open();
        send_line(CW, base, -1);
        send_line(CW, base + CW, -1);
        send_line(CW, base + 2 * CW, -1);
        frame_close();
    endtask

    task automatic start_capture;
        tick(1'b0, 1'b0, 0, 1'b1, 1'b0);
        idle(4);
    endtask

    task automatic apply_reset;
        iRST = 1'b1;
        idle(3);
        iRST = 1'b0;
        idle(2);
        logQ.delete();
        drvQ.delete();
    endtask

    task automatic test_reset;
        iRST = 1'b1;
        for (int i = 0; i < 5; i++) tick(i[0], 1'b1, 100 + i, 1'b0, 1'b0);
        checks++; if (oDATA !== 12'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", oDATA); end
        checks++; if (oDVAL !== 1'b0) begin errors++; $display("FAIL reset_dval: got %0b expected 0", oDVAL); end
        checks++; if (oX_Cont !== 11'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", oX_Cont); end
        checks++; if (oY_Cont !== 11'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", oY_Cont); end
        checks++; if (oFrame_Cont !== 32'd0) begin errors++; $display("FAIL reset_frame: got %0d expected 0", oFrame_Cont); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", oBusy); end
        iRST = 1'b0;
        logQ.delete();
        send_frame(0);
        checks++; if (logQ.size() != 0) begin errors++; $display("FAIL idle_nodval: got %0d beats expected 0", logQ.size()); end
        checks++; if (oFrame_Cont !== 32'd0) begin errors++; $display("FAIL idle_frame: got %0d expected 0", oFrame_Cont); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", oBusy); end
        checks++; if (oX_Cont !== 11'd0 || oY_Cont !== 11'd0 || oDATA !== 12'd0) begin
            errors++; $display("FAIL idle_hold: got x=%0d y=%0d d=%0d expected 0 0 0", oX_Cont, oY_Cont, oDATA);
        end
    endtask

    task automatic test_basic_frame;
        int n;
        apply_reset();
        start_capture();
        drvQ.delete();
        send_frame(0);
        checks++; if (logQ.size() != 12) begin errors++; $display("FAIL basic_count: got %0d beats expected 12", logQ.size()); end
        n = (logQ.size() < 12) ? logQ.size() : 12;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (logQ[i].data != i || logQ[i].x != i % 4 || logQ[i].y != i / 4) begin
                errors++;
                $display("FAIL basic_pix[%0d]: got d=%0d x=%0d y=%0d expected d=%0d x=%0d y=%0d",
                         i, logQ[i].data, logQ[i].x, logQ[i].y, i, i % 4, i / 4);
            end
        end
        checks++; if (drvQ.size() != 12) begin errors++; $display("FAIL basic_drv: got %0d driven expected 12", drvQ.size()); end
        for (int i = 0; i < n && i < drvQ.size(); i++) begin
            checks++;
            if (logQ[i].cyc - drvQ[i] != 2) begin
                errors++; $display("FAIL basic_latency[%0d]: got %0d cycles expected 2", i, logQ[i].cyc - drvQ[i]);
            end
        end
        checks++; if (oFrame_Cont !== 32'd1) begin errors++; $display("FAIL basic_frame: got %0d expected 1", oFrame_Cont); end
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b expected 1", oBusy); end
        checks++; if (oDVAL !== 1'b0) begin errors++; $display("FAIL basic_dval_low: got %0b expected 0", oDVAL); end
    endtask

    task automatic test_partial_skip;
        apply_reset();
        frame_open();
        send_line(CW, 200, -1);
        tick(1'b1, 1'b0, 0, 1'b1, 1'b0);
        send_line(CW, 204, -1);
        send_line(CW, 208, -1);
        frame_close();
        checks++; if (logQ.size() != 0) begin errors++; $display("FAIL skip_nodval: got %0d beats expected 0", logQ.size()); end
        checks++; if (oFrame_Cont !== 32'd0) begin errors++; $display("FAIL skip_frame0: got %0d expected 0", oFrame_Cont); end
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL skip_busy: got %0b expected 1", oBusy); end
        send_frame(0);
        checks++; if (logQ.size() != 12) begin errors++; $display("FAIL skip_count: got %0d beats expected 12", logQ.size()); end
        if (logQ.size() > 0) begin
            checks++;
            if (logQ[0].data != 0 || logQ[0].x != 0 || logQ[0].y != 0) begin
                errors++; $display("FAIL skip_first: got d=%0d x=%0d y=%0d expected 0 0 0", logQ[0].data, logQ[0].x, logQ[0].y);
            end
        end
        if (logQ.size() == 12) begin
            checks++;
            if (logQ[11].data != 11 || logQ[11].x != 3 || logQ[11].y != 2) begin
                errors++; $display("FAIL skip_last: got d=%0d x=%0d y=%0d expected 11 3 2", logQ[11].data, logQ[11].x, logQ[11].y);
            end
        end
        checks++; if (oFrame_Cont !== 32'd1) begin errors++; $display("FAIL skip_frame1: got %0d expected 1", oFrame_Cont); end
    endtask

    task automatic test_stop_mid_frame;
        int n;
        apply_reset();
        start_capture();
        frame_open();
        send_line(CW, 0, -1);
        send_line(CW, 4, 1);
        send_line(CW, 8, -1);
        frame_close();
        checks++; if (logQ.size() != 12) begin errors++; $display("FAIL stop_count: got %0d beats expected 12", logQ.size()); end
        n = (logQ.size() < 12) ? logQ.size() : 12;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (logQ[i].data != i || logQ[i].x != i % 4 || logQ[i].y != i / 4) begin
                errors++;
                $display("FAIL stop_pix[%0d]: got d=%0d x=%0d y=%0d expected d=%0d x=%0d y=%0d",
                         i, logQ[i].data, logQ[i].x, logQ[i].y, i, i % 4, i / 4);
            end
        end
        checks++; if (oFrame_Cont !== 32'd1) begin errors++; $display("FAIL stop_frame: got %0d expected 1", oFrame_Cont); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %0b expected 0", oBusy); end
        send_frame(50);
        checks++; if (logQ.size() != 12) begin errors++; $display("FAIL stop_after: got %0d beats expected 12", logQ.size()); end
        checks++; if (oFrame_Cont !== 32'd1) begin errors++; $display("FAIL stop_frame_after: got %0d expected 1", oFrame_Cont); end
    endtask

    task automatic test_short_line_wrap;
        int exX[14] = '{0, 1, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        int exY[14] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0, 0, 0, 0};
        int n;
        apply_reset();
        start_capture();
        frame_open();
        send_line(2, 0, -1);
        send_line(CW, 2, -1);
        send_line(CW, 6, -1);
        send_line(CW, 10, -1);
        frame_close();
        checks++; if (logQ.size() != 14) begin errors++; $display("FAIL wrap_count: got %0d beats expected 14", logQ.size()); end
        n = (logQ.size() < 14) ? logQ.size() : 14;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (logQ[i].data != i || logQ[i].x != exX[i] || logQ[i].y != exY[i]) begin
                errors++;
                $display("FAIL wrap_pix[%0d]: got d=%0d x=%0d y=%0d expected d=%0d x=%0d y=%0d",
                         i, logQ[i].data, logQ[i].x, logQ[i].y, i, exX[i], exY[i]);
            end
        end
        checks++; if (oFrame_Cont !== 32'd1) begin errors++; $display("FAIL wrap_frame: got %0d expected 1", oFrame_Cont); end
    endtask

    task automatic test_back_to_back;
        int n;
        apply_reset();
        start_capture();
        send_frame(0);
        tick(1'b0, 1'b1, 55, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 56, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 57, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 0, 1'b0, 1'b0);
        send_frame(100);
        checks++; if (logQ.size() != 24) begin errors++; $display("FAIL b2b_count: got %0d beats expected 24", logQ.size()); end
        n = (logQ.size() < 24) ? logQ.size() : 24;
        for (int i = 0; i < n; i++) begin
            int k;
            int d;
            k = i % 12;
            d = (i < 12) ? i : 100 + k;
            checks++;
            if (logQ[i].data != d || logQ[i].x != k % 4 || logQ[i].y != k / 4) begin
                errors++;
                $display("FAIL b2b_pix[%0d]: got d=%0d x=%0d y=%0d expected d=%0d x=%0d y=%0d",
                         i, logQ[i].data, logQ[i].x, logQ[i].y, d, k % 4, k / 4);
            end
        end
        checks++; if (oFrame_Cont !== 32'd2) begin errors++; $display("FAIL b2b_frame: got %0d expected 2", oFrame_Cont); end
    endtask

    task automatic test_start_end_same;
        apply_reset();
        tick(1'b0, 1'b0, 0, 1'b1, 1'b1);
        idle(3);
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL se_busy: got %0b expected 0", oBusy); end
        send_frame(0);
        checks++; if (logQ.size() != 0) begin errors++; $display("FAIL se_nodval: got %0d beats expected 0", logQ.size()); end
        checks++; if (oFrame_Cont !== 32'd0) begin errors++; $display("FAIL se_frame: got %0d expected 0", oFrame_Cont); end
    endtask

    task automatic test_reset_mid_frame;
        apply_reset();
        start_capture();
        frame_open();
        send_line(CW, 0, -1);
        tick(1'b1, 1'b1, 4, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 5, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 6, 1'b0, 1'b0);
        checks++; if (oDVAL !== 1'b1 || oDATA !== 12'd4 || oX_Cont !== 11'd0 || oY_Cont !== 11'd1) begin
            errors++; $display("FAIL rst_pre: got v=%0b d=%0d x=%0d y=%0d expected 1 4 0 1", oDVAL, oDATA, oX_Cont, oY_Cont);
        end
        iRST = 1'b1;
        tick(1'b1, 1'b1, 7, 1'b0, 1'b0);
        checks++; if (oDVAL !== 1'b0) begin errors++; $display("FAIL rst_dval: got %0b expected 0", oDVAL); end
        checks++; if (oDATA !== 12'd0) begin errors++; $display("FAIL rst_data: got %0d expected 0", oDATA); end
        checks++; if (oX_Cont !== 11'd0 || oY_Cont !== 11'd0) begin
            errors++; $display("FAIL rst_xy: got x=%0d y=%0d expected 0 0", oX_Cont, oY_Cont);
        end
        checks++; if (oFrame_Cont !== 32'd0) begin errors++; $display("FAIL rst_frame: got %0d expected 0", oFrame_Cont); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", oBusy); end
        iRST = 1'b0;
        logQ.delete();
        tick(1'b1, 1'b1, 8, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
        send_line(CW, 12, -1);
        frame_close();
        send_frame(0);
        checks++; if (logQ.size() != 0) begin errors++; $display("FAIL rst_nodval: got %0d beats expected 0", logQ.size()); end
        checks++; if (oFrame_Cont !== 32'd0) begin errors++; $display("FAIL rst_frame_after: got %0d expected 0", oFrame_Cont); end
    endtask

    initial begin
        iRST   = 1'b1;
        iSTART = 1'b0;
        iEND   = 1'b0;
        iFVAL  = 1'b0;
        iLVAL  = 1'b0;
        iDATA  = 12'd0;
        test_reset();
        test_basic_frame();
        test_partial_skip();
        test_stop_mid_frame();
        test_short_line_wrap();
        test_back_to_back();
        test_start_end_same();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/raw_capture.md
# raw_capture

Sensor-side capture block that turns raw camera timing (frame valid, line valid, 12-bit Bayer pixel) into the coordinate-tagged pixel stream consumed by the image processing block: pixel data, data-valid, X/Y counters and a frame counter. It sits between the camera pins and image processing, and is the producer of the `X_Cont`/`Y_Cont`/`DATA`/`DVAL` interface. It gates capture with start/stop controls so that only whole frames are ever forwarded.

## Interface
- `COLUMN_WIDTH`, 1280: pixels per line; X counter wraps here.
- `ROW_HEIGHT`, 960: lines per frame; Y counter wraps here.
- `iCLK` in 1: pixel clock; all logic on rising edge.
- `iRST` in 1: synchronous, active-high reset.
- `iSTART` in 1: capture enable request, sampled each cycle.
- `iEND` in 1: capture stop request, sampled each cycle.
- `iFVAL` in 1: sensor frame valid.
- `iLVAL` in 1: sensor line valid.
- `iDATA` in 12: sensor raw pixel.
- `oDATA` out 12: captured pixel.
- `oDVAL` out 1: `oDATA`/`oX_Cont`/`oY_Cont` valid this cycle.
- `oX_Cont` out 11: column of pixel on `oDATA`.
- `oY_Cont` out 11: row of pixel on `oDATA`.
- `oFrame_Cont` out 32: completed frames captured.
- `oBusy` out 1: high whenever state is not IDLE.

## Operation
- Input stage: `iFVAL`, `iLVAL` and `iDATA` are registered once (`rF`, `rL`, `rD`). Previous values `rF_d` and `rL_d` are kept for edge detection. All control decisions use the registered copies.
- Run flag: set by `iSTART` and cleared by `iEND`. If both are high in the same cycle, `iEND` wins and the flag is cleared.
- FSM:
  - **IDLE**: go to WAIT_LOW when run=1.
  - **WAIT_LOW**: wait for `rF`=0, so a frame already in progress is never captured; then go to WAIT_FRAME. Go to IDLE if run=0.
  - **WAIT_FRAME**: a rising `rF` goes to ACTIVE and sets X=0, Y=0. Go to IDLE if run=0.
  - **ACTIVE**: pixels are forwarded. A falling `rF` increments `oFrame_Cont`, then goes to WAIT_FRAME if run=1, else IDLE.
- Clearing the run flag during ACTIVE does not abort the frame. The frame completes and is counted.
- Pixel forwarding happens in ACTIVE when `rL`=1 and `rF`=1.
  - Output registers: `oDATA`←`rD`, `oDVAL`←1, `oX_Cont`/`oY_Cont`← current counters.
  - Counter advance: X increments. At X=`COLUMN_WIDTH`-1, X wraps to 0 and Y increments. At Y=`ROW_HEIGHT`-1 the increment wraps Y to 0.
- Short line: a falling `rL` with X≠0 forces X=0 and Y+1, using the same Y wrap rule. A falling `rL` with X=0 does nothing further, because the wrap already advanced Y.
- Outside a forwarding cycle, `oDVAL`=0. `oDATA`, `oX_Cont` and `oY_Cont` hold their last values.
- `oFrame_Cont` wraps modulo 2^32. Frames that are never entered in ACTIVE are not counted.

## Timing
- Reset values: `oDATA`=0, `oDVAL`=0, `oX_Cont`=0, `oY_Cont`=0, `oFrame_Cont`=0, `oBusy`=0. State=IDLE, run=0, input registers=0.
- Reset mid-frame: all of the above take effect on the next edge. No frame is counted, and capture restarts only after a new `iSTART`.
- Latency: a pixel presented on `iDATA` with `iLVAL`=1 at edge n appears on `oDATA` with `oDVAL`=1 at edge n+2.
- Throughput: one pixel per cycle, no stall or back-pressure.
- `iSTART` at edge n sets run at n+1; the first possible ACTIVE entry follows.
- A frame-end increment is visible on `oFrame_Cont` 2 edges after `iFVAL` falls. `oDVAL` is guaranteed low from that edge on.
- `iLVAL` with `iFVAL`=0 never produces `oDVAL`.

## Test plan
- Reset and idle: hold `iRST`=1 for 5 cycles, then release with sensor toggling and no `iSTART` → all outputs stay 0, `oBusy`=0.
- Basic frame (`COLUMN_WIDTH`=4, `ROW_HEIGHT`=3): `iSTART` pulse, then a 3-line × 4-pixel frame with data 0..11 → `oDVAL` high for 12 cycles. `oX_Cont` runs 0,1,2,3 and `oY_Cont` runs 0,1,2, with `oDATA` equal to the pixel index, each 2 cycles after input. `oFrame_Cont`=1.
- Partial-frame skip: assert `iSTART` while `iFVAL` is already high mid-frame → no `oDVAL` for that frame. The next full frame is captured with X=0, Y=0 first.
- Stop mid-frame: pulse `iEND` during line 1 → the frame completes with all 12 pixels and `oFrame_Cont`=1. State returns to IDLE, `oBusy`=0, and a following frame produces no `oDVAL`.
- Short line and wrap: send a 2-pixel line, then a 4-pixel line → coordinates (0,0) (1,0), then (0,1)..(3,1). Send a 4th full line in a frame → Y wraps to 0.
- Simultaneous `iSTART`+`iEND` in IDLE → run stays 0, no capture. Mid-frame `iRST` → `oFrame_Cont` unchanged at 0 and outputs cleared next edge.
